addsub_overflow_acc: RTL

ADDSUB_OVERFLOW_ACC -- requirements
Module: addsub_overflow_acc

---
 rtl/addsub_overflow_acc.sv | 119 +++++++++++
 1 files changed

// File: rtl/addsub_overflow_acc.sv
// Signed add/subtract accumulator with carry, overflow, sticky overflow and a saturating
// overflow-event counter. Define ADDSUB_SATURATE_EN to clamp ACC on overflow instead of wrapping.
module addsub_overflow_acc #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic [1:0]           OP,
    input  logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     ACC,
    output logic                 CO,
    output logic                 OVF,
    output logic                 OVF_STICKY,
    output logic [CNT_WIDTH-1:0] OVF_CNT,
    output logic                 OUT_VALID
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 co_q, co_d;
    logic                 ovf_q, ovf_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH-1:0]     operand;
    logic [WIDTH:0]       raw;
    logic                 op_ovf;

`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // SUB shares the adder as ACC + ~D + 1, so CO=1 on SUB means "no borrow".
    always_comb begin
        operand = (op_e'(OP) == OP_SUB) ? ~D : D;
        raw     = {1'b0, acc_q} + {1'b0, operand}
                + {{WIDTH{1'b0}}, (op_e'(OP) == OP_SUB)};
        // Overflow iff both adder inputs share a sign and the result sign flips away from it.
        op_ovf  = (acc_q[WIDTH-1] == operand[WIDTH-1]) && (raw[WIDTH-1] != acc_q[WIDTH-1]);
    end

    // Valid/ready: no ready exists; every cycle with IN_VALID=1 is one accepted operation,
    // and OUT_VALID pulses in the cycle after acceptance.
    always_comb begin
        acc_d       = acc_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        out_valid_d = IN_VALID;
        if (IN_VALID) begin
            case (op_e'(OP))
                OP_LOAD: begin
                    acc_d = D;
                    co_d  = 1'b0;
                    ovf_d = 1'b0;
                end
                OP_ADD, OP_SUB: begin
`ifdef ADDSUB_SATURATE_EN
                    // On overflow the true result carries ACC's sign.
                    if (op_ovf) acc_d = acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                    else        acc_d = raw[WIDTH-1:0];
`else
                    acc_d = raw[WIDTH-1:0];
`endif
                    co_d  = raw[WIDTH];
                    ovf_d = op_ovf;
                    if (op_ovf) begin
                        sticky_d = 1'b1;
                        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    acc_d    = '0;
                    co_d     = 1'b0;
                    ovf_d    = 1'b0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q       <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ACC        = acc_q;
    assign CO         = co_q;
    assign OVF        = ovf_q;
    assign OVF_STICKY = sticky_q;
    assign OVF_CNT    = cnt_q;
    assign OUT_VALID  = out_valid_q;

endmodule
